dmem_lsu: RTL

// Load/store initiator that sits between the CPU execute stage and the word-wide data memory.

---
 rtl/dmem_lsu.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit between the execute stage and a word-wide data memory.
// Handles byte/half/word accesses, read-modify-write for sub-word stores and
// sign/zero extension for loads. Optional macro LSU_MISALIGN_TRAP_EN turns
// misaligned half/word accesses into errors; otherwise low bits are ignored.
module dmem_lsu #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    // One extra bit so the limit itself is representable for any ADDR_W.
    localparam logic [ADDR_W:0] ADDR_LIMIT = ((ADDR_W + 1)'(MEM_WORDS)) << 2;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word_q;
    logic              err_q;
    logic              req_err;
    logic              accept;
    logic [31:0]       merged;

    assign accept = req_valid && (state_q == IDLE);

    // Classify an incoming request as rejected before it touches memory.
    always_comb begin
        req_err = 1'b0;
        if (req_size == SIZE_RSVD) req_err = 1'b1;
        if ({1'b0, req_addr} >= ADDR_LIMIT) req_err = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        if (req_size == SIZE_HALF && req_addr[0]) req_err = 1'b1;
        if (req_size == SIZE_WORD && req_addr[1:0] != 2'b00) req_err = 1'b1;
`endif
    end

    // State register plus latched request fields and the captured memory word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                wdata_q <= req_wdata;
                err_q   <= req_err;
            end
            if (state_q == RD) word_q <= mem_rdata;
        end
    end

    // Next-state: errors skip memory, word stores skip the read phase.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_err) state_d = RESP;
                    else if (req_we && req_size == SIZE_WORD) state_d = WR;
                    else state_d = RD;
                end
            end
            RD:      state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // Write data: replace the addressed lane of the captured word.
    always_comb begin
        merged = word_q;
        case (size_q)
            SIZE_BYTE: merged[8 * addr_q[1:0] +: 8] = wdata_q[7:0];
            SIZE_HALF: merged[16 * addr_q[1] +: 16] = wdata_q[15:0];
            default:   merged = wdata_q;
        endcase
    end

    // Load data: pick the lane and extend; zero for stores and errors.
    always_comb begin
        resp_rdata = '0;
        if (state_q == RESP && !err_q && !we_q) begin
            case (size_q)
                SIZE_BYTE: begin
                    resp_rdata[7:0]  = word_q[8 * addr_q[1:0] +: 8];
                    resp_rdata[31:8] = {24{!uns_q && resp_rdata[7]}};
                end
                SIZE_HALF: begin
                    resp_rdata[15:0]  = word_q[16 * addr_q[1] +: 16];
                    resp_rdata[31:16] = {16{!uns_q && resp_rdata[15]}};
                end
                default: resp_rdata = word_q;
            endcase
        end
    end

    // Memory port and handshake outputs decoded from the state. A reset
    // arriving in WR suppresses the write so an aborted RMW never lands.
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_err   = (state_q == RESP) && err_q;
        mem_we     = (state_q == WR) && !rst;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (state_q == RD || state_q == WR) mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        if (state_q == WR) mem_wdata = merged;
    end

endmodule
